// File: rtl/ext_interrupt_controller.sv
// Edge-triggered external interrupt controller for 16 GPIO pins. A small bus-mapped
// register set and a three-state request/service handshake toward the CPU.
module ext_interrupt_controller #(
   parameter logic [31:0] BASE_ADDR = 32'h4040
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] pin_state,
   input  logic [15:0] data_bus_write,
   output logic [15:0] data_bus_read,
   input  logic [31:0] data_bus_addr,
   input  logic [1:0]  data_bus_mode,
   input  logic        data_bus_select,
   output logic        irq_req,
   output logic [3:0]  irq_id,
   input  logic        irq_ack,
   input  logic        irq_eoi
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_REQ     = 2'b01,
      ST_SERVICE = 2'b10
   } state_t;

   logic [15:0] r_enable;
   logic [15:0] r_rise_sel;
   logic [15:0] r_fall_sel;
   logic [15:0] r_pending;
   logic [15:0] r_prev;
   state_t      r_state;
   logic        r_irq_req;
   logic [3:0]  r_irq_id;

   logic        w_wr;
   logic        w_wr_enable;
   logic        w_wr_rise;
   logic        w_wr_fall;
   logic        w_wr_pending;
   logic [15:0] w_edge_set;
   logic [15:0] w_ack_clr;
   logic [15:0] w_w1c_clr;
   logic [15:0] w_pending_nxt;
   logic [15:0] w_enable_nxt;
   logic [15:0] w_candidate;
   logic [3:0]  w_winner;
   state_t      w_state_nxt;
   logic        w_latch_id;

   assign w_wr         = data_bus_select && (data_bus_mode == 2'b10);
   assign w_wr_enable  = w_wr && (data_bus_addr == BASE_ADDR);
   assign w_wr_rise    = w_wr && (data_bus_addr == BASE_ADDR + 32'd4);
   assign w_wr_fall    = w_wr && (data_bus_addr == BASE_ADDR + 32'd8);
   assign w_wr_pending = w_wr && (data_bus_addr == BASE_ADDR + 32'd12);

   assign w_edge_set = (pin_state & ~r_prev & r_rise_sel) | (~pin_state & r_prev & r_fall_sel);
   assign w_ack_clr  = ((r_state == ST_REQ) && irq_ack) ? (16'h0001 << r_irq_id) : 16'h0000;
   assign w_w1c_clr  = w_wr_pending ? data_bus_write : 16'h0000;

   // New edges are OR-ed in after the clears so a coincident set always survives.
   assign w_pending_nxt = (r_pending & ~(w_w1c_clr | w_ack_clr)) | w_edge_set;
   assign w_enable_nxt  = w_wr_enable ? data_bus_write : r_enable;
   assign w_candidate   = r_pending & r_enable;

   always_comb begin
      w_winner = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (w_candidate[i]) w_winner = 4'(i);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_latch_id  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_candidate != 16'h0000) begin
               w_latch_id  = 1'b1;
               w_state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            // Withdraw based on next-cycle pending/enable so a software clear drops irq_req one cycle later.
            if (irq_ack)
               w_state_nxt = ST_SERVICE;
            else if (!(w_pending_nxt[r_irq_id] && w_enable_nxt[r_irq_id]))
               w_state_nxt = ST_IDLE;
         end
         ST_SERVICE: begin
            if (irq_eoi) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_enable   <= 16'h0000;
         r_rise_sel <= 16'h0000;
         r_fall_sel <= 16'h0000;
         r_pending  <= 16'h0000;
         r_prev     <= 16'h0000;
         r_state    <= ST_IDLE;
         r_irq_req  <= 1'b0;
         r_irq_id   <= 4'd0;
      end else begin
         r_prev    <= pin_state;
         r_pending <= w_pending_nxt;
         r_enable  <= w_enable_nxt;
         if (w_wr_rise) r_rise_sel <= data_bus_write;
         if (w_wr_fall) r_fall_sel <= data_bus_write;
         r_state   <= w_state_nxt;
         r_irq_req <= (w_state_nxt == ST_REQ);
         if (w_latch_id) r_irq_id <= w_winner;
      end
   end

   always_comb begin
      data_bus_read = 16'h0000;
      if (data_bus_addr == BASE_ADDR)
         data_bus_read = r_enable;
      else if (data_bus_addr == BASE_ADDR + 32'd4)
         data_bus_read = r_rise_sel;
      else if (data_bus_addr == BASE_ADDR + 32'd8)
         data_bus_read = r_fall_sel;
      else if (data_bus_addr == BASE_ADDR + 32'd12)
         data_bus_read = r_pending;
      else if (data_bus_addr == BASE_ADDR + 32'd16)
         data_bus_read = {4'b0000, r_irq_id, 2'b00, r_state, 3'b000, r_irq_req};
   end

   assign irq_req = r_irq_req;
   assign irq_id  = r_irq_id;

endmodule
